ssd_scan: RTL and testbench

Parametrised, time-multiplexed seven-segment display controller for the Nexys A7 debug builds. It scans `NUM_DIGITS` hexadecimal digits onto shared cathodes and one-hot anodes, and adds PWM brightness, per-digit decimal points and leading-zero suppression. Frame-synchronous value updates prevent tearing while a Manta core drives `val` at logic rate. It replaces the fixed 8-digit driver in board top levels and runs in the same clock domain as the Manta core.

---
 rtl/ssd_pkg.sv | 33 +++
 rtl/ssd_pwm_timer.sv | 54 +++++
 rtl/ssd_scan.sv | 157 +++++++++++++++
 tb/tb_ssd_scan.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and glyph decoding for the seven-segment scan controller.
// Segment patterns here are active-high; output polarity is applied at the top.
package ssd_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b0000000;

   // Bit order {g,f,e,d,c,b,a}; b and d are the lowercase forms.
   function automatic seg_t hex_to_seg(input logic [3:0] hex);
      seg_t seg;
      unique case (hex)
         4'h0: seg = 7'b0111111;
         4'h1: seg = 7'b0000110;
         4'h2: seg = 7'b1011011;
         4'h3: seg = 7'b1001111;
         4'h4: seg = 7'b1100110;
         4'h5: seg = 7'b1101101;
         4'h6: seg = 7'b1111101;
         4'h7: seg = 7'b0000111;
         4'h8: seg = 7'b1111111;
         4'h9: seg = 7'b1101111;
         4'hA: seg = 7'b1110111;
         4'hB: seg = 7'b1111100;
         4'hC: seg = 7'b0111001;
         4'hD: seg = 7'b1011110;
         4'hE: seg = 7'b1111001;
         default: seg = 7'b1110001;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/ssd_pwm_timer.sv
// Slot timing for the scan: prescaler, PWM sub-slot counter and digit index.
// Each digit slot is exactly SUB_CYCLES << BRIGHT_BITS clocks long.
module ssd_pwm_timer
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int SUB_CYCLES  = 1,
   parameter int BRIGHT_BITS = 4,
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [BRIGHT_BITS-1:0] sub,
   output logic [DW-1:0]          digit_idx,
   output logic                   slot_start,
   output logic                   frame_wrap
);

   localparam int PW = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;

   logic [PW-1:0]          presc_reg;
   logic [BRIGHT_BITS-1:0] sub_reg;
   logic [DW-1:0]          digit_reg;

   logic presc_last;
   logic sub_last;
   logic digit_last;

   assign presc_last = (presc_reg == PW'(SUB_CYCLES - 1));
   assign sub_last   = &sub_reg;
   assign digit_last = (digit_reg == DW'(NUM_DIGITS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_reg <= '0;
         sub_reg   <= '0;
         digit_reg <= '0;
      end else begin
         presc_reg <= presc_last ? '0 : presc_reg + 1'b1;
         if (presc_last) begin
            sub_reg <= sub_reg + 1'b1;
            if (sub_last) begin
               digit_reg <= digit_last ? '0 : digit_reg + 1'b1;
            end
         end
      end
   end

   assign sub        = sub_reg;
   assign digit_idx  = digit_reg;
   assign slot_start = (presc_reg == '0) && (sub_reg == '0);
   assign frame_wrap = presc_last && sub_last && digit_last;

endmodule

// File: rtl/ssd_scan.sv
// Time-multiplexed hex display driver with PWM brightness, decimal points,
// leading-zero suppression and frame-synchronous value updates.
module ssd_scan
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int REFRESH_HZ  = 1000,
   parameter int BRIGHT_BITS = 4,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] val,
   input  logic                    val_valid,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    lz_blank,
   input  logic [BRIGHT_BITS-1:0]  brightness,
   output logic [6:0]              cat,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int   DIGIT_CYCLES = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
   localparam int   SUB_CYCLES   = DIGIT_CYCLES >> BRIGHT_BITS;
   localparam int   DW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic POL          = (ACTIVE_LOW != 0);

   generate
      if (SUB_CYCLES < 1) begin : g_bad_timing
         $error("ssd_scan: clock too slow for REFRESH_HZ/NUM_DIGITS/BRIGHT_BITS");
      end
      if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
         $error("ssd_scan: NUM_DIGITS must be 1..16");
      end
   endgenerate

   logic [BRIGHT_BITS-1:0] sub;
   logic [DW-1:0]          digit_idx;
   logic                   slot_start;
   logic                   frame_wrap;

   ssd_pwm_timer #(
      .NUM_DIGITS (NUM_DIGITS),
      .SUB_CYCLES (SUB_CYCLES),
      .BRIGHT_BITS(BRIGHT_BITS)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .sub       (sub),
      .digit_idx (digit_idx),
      .slot_start(slot_start),
      .frame_wrap(frame_wrap)
   );

   logic [4*NUM_DIGITS-1:0] disp_val_reg;
   logic [NUM_DIGITS-1:0]   disp_dp_reg;
   logic [4*NUM_DIGITS-1:0] pend_val_reg;
   logic [NUM_DIGITS-1:0]   pend_dp_reg;
   logic                    pend_valid_reg;
   logic [BRIGHT_BITS-1:0]  bright_q_reg;

   // A strobe landing on the wrap cycle goes straight to the display.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_val_reg   <= '0;
         disp_dp_reg    <= '0;
         pend_val_reg   <= '0;
         pend_dp_reg    <= '0;
         pend_valid_reg <= 1'b0;
      end else if (frame_wrap) begin
         if (val_valid) begin
            disp_val_reg <= val;
            disp_dp_reg  <= dp;
         end else if (pend_valid_reg) begin
            disp_val_reg <= pend_val_reg;
            disp_dp_reg  <= pend_dp_reg;
         end
         pend_valid_reg <= 1'b0;
      end else if (val_valid) begin
         pend_val_reg   <= val;
         pend_dp_reg    <= dp;
         pend_valid_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bright_q_reg <= '0;
      end else if (slot_start) begin
         bright_q_reg <= brightness;
      end
   end

   logic [3:0]            nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] nz;
   logic [NUM_DIGITS-1:0] keep;

   // A digit survives suppression if it or any more significant nibble is nonzero.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign nib[gi] = disp_val_reg[4*gi +: 4];
         assign nz[gi]  = |disp_val_reg[4*gi +: 4];
         if (gi == 0) begin : g_lsd
            assign keep[gi] = 1'b1;
         end else begin : g_upper
            assign keep[gi] = |nz[NUM_DIGITS-1:gi];
         end
      end
   endgenerate

   // Sub-slot 0 is always lit, so a bright_q latched at slot start is never late.
   logic lit;
   assign lit = (sub <= bright_q_reg) && !(lz_blank && !keep[digit_idx]);

   logic [NUM_DIGITS-1:0] an_next;
   seg_t                  cat_next;
   logic                  dp_next;
   logic                  fs_next;

   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
         assign an_next[gi] = lit && (digit_idx == DW'(gi));
      end
   endgenerate

   assign cat_next = lit ? hex_to_seg(nib[digit_idx]) : SEG_BLANK;
   assign dp_next  = lit && disp_dp_reg[digit_idx];
   assign fs_next  = slot_start && (digit_idx == '0);

   logic [NUM_DIGITS-1:0] an_reg;
   seg_t                  cat_reg;
   logic                  dp_out_reg;
   logic                  frame_start_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_reg          <= {NUM_DIGITS{POL}};
         cat_reg         <= {7{POL}};
         dp_out_reg      <= POL;
         frame_start_reg <= 1'b0;
      end else begin
         an_reg          <= an_next ^ {NUM_DIGITS{POL}};
         cat_reg         <= cat_next ^ {7{POL}};
         dp_out_reg      <= dp_next ^ POL;
         frame_start_reg <= fs_next;
      end
   end

   assign an          = an_reg;
   assign cat         = cat_reg;
   assign dp_out      = dp_out_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_ssd_scan.sv
// Directed bench for ssd_scan: a frame-position model checked every cycle,
// plus hand-computed glyph/anode/duty expectations at chosen cycles.
module tb_ssd_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] val = 16'h0000;
   logic        val_valid = 1'b0;
   logic [3:0]  dp = 4'b0000;
   logic        lz_blank = 1'b0;
   logic [1:0]  brightness = 2'd3;
   logic [6:0]  cat;
   logic        dp_out;
   logic [3:0]  an;
   logic        frame_start;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ssd_scan #(
      .NUM_DIGITS (4),
      .CLK_FREQ_HZ(1600),
      .REFRESH_HZ (25),
      .BRIGHT_BITS(2),
      .ACTIVE_LOW (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .val        (val),
      .val_valid  (val_valid),
      .dp         (dp),
      .lz_blank   (lz_blank),
      .brightness (brightness),
      .cat        (cat),
      .dp_out     (dp_out),
      .an         (an),
      .frame_start(frame_start)
   );

   // Active-high glyphs {g,f,e,d,c,b,a} for 0..F.
   logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Model: position 0..63 in the frame; 16 cycles per digit, 4 per sub-slot.
   int          m_pos = 0;
   int          m_bright = 0;
   logic [15:0] m_val = '0, m_pend = '0;
   logic [3:0]  m_dp = '0, m_pend_dp = '0;
   logic        m_pend_v = 1'b0;
   logic [3:0]  exp_an = 4'hF;
   logic [6:0]  exp_cat = 7'h7F;
   logic        exp_dp = 1'b1;
   logic        exp_fs = 1'b0;

   function automatic logic lit_model(int pos, int b, logic [15:0] v, logic lz);
      int top = 0;
      for (int i = 0; i < 4; i++) if (v[4*i +: 4] != 4'd0) top = i;
      return ((pos % 16) / 4 <= b) && !(lz && (pos / 16) > top);
   endfunction

   int   slot_b;
   logic m_lit;
   assign slot_b = (m_pos % 16 == 0) ? int'(brightness) : m_bright;
   assign m_lit  = lit_model(m_pos, slot_b, m_val, lz_blank);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pos <= 0; m_bright <= 0;
         m_val <= '0; m_pend <= '0; m_dp <= '0; m_pend_dp <= '0; m_pend_v <= 1'b0;
         exp_an <= 4'hF; exp_cat <= 7'h7F; exp_dp <= 1'b1; exp_fs <= 1'b0;
      end else begin
         m_bright <= slot_b;
         exp_an   <= m_lit ? ~(4'b0001 << (m_pos / 16)) : 4'hF;
         exp_cat  <= m_lit ? ~glyph_tab[m_val[4*(m_pos/16) +: 4]] : 7'h7F;
         exp_dp   <= !(m_lit && m_dp[m_pos/16]);
         exp_fs   <= (m_pos == 0);
         if (m_pos == 63) begin
            if (val_valid) begin
               m_val <= val; m_dp <= dp;
            end else if (m_pend_v) begin
               m_val <= m_pend; m_dp <= m_pend_dp;
            end
            m_pend_v <= 1'b0;
         end else if (val_valid) begin
            m_pend <= val; m_pend_dp <= dp; m_pend_v <= 1'b1;
         end
         m_pos <= (m_pos + 1) % 64;
      end
   end

   int edge_cnt = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) edge_cnt <= 0;
      else     edge_cnt <= edge_cnt + 1;
   end

   logic [3:0] an_hist [1024];

   task automatic wait_edge(input int e);
      do begin
         @(posedge clk);
         #1;
      end while (edge_cnt < e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %b required %b", name, act, req);
      end else begin
         $display("check %s ok (%b)", name, act);
      end
   endtask

   task automatic strobe(input int e, input logic [15:0] v, input logic [3:0] d);
      wait_edge(e);
      #2;
      val = v; dp = d; val_valid = 1'b1;
      $display("strobe val=%h dp=%b after edge %0d", v, d, e);
      wait_edge(e + 1);
      #2;
      val_valid = 1'b0;
   endtask

   function automatic int count_on(int first, int last, int digit);
      int n = 0;
      for (int e = first; e <= last; e++) if (an_hist[e][digit] == 1'b0) n++;
      return n;
   endfunction

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (edge_cnt < 1024) an_hist[edge_cnt] = an;
            vectors++;
            if ({an, cat, dp_out, frame_start} !== {exp_an, exp_cat, exp_dp, exp_fs}) begin
               miscompares++;
               $display("FAIL cycle t=%0t: an=%b cat=%b dp=%b fs=%b required an=%b cat=%b dp=%b fs=%b",
                        $time, an, cat, dp_out, frame_start, exp_an, exp_cat, exp_dp, exp_fs);
            end
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_an", 32'(an), 32'(4'b1111));
      check("reset_cat", 32'(cat), 32'(7'b1111111));
      check("reset_dp", 32'(dp_out), 32'(1'b1));
      check("reset_fs", 32'(frame_start), 32'(1'b0));
      #2;
      rst = 1'b0;

      wait_edge(1);
      check("first_an", 32'(an), 32'(4'b1110));
      check("first_cat0", 32'(cat), 32'(7'b1000000));
      check("first_fs", 32'(frame_start), 32'(1'b1));

      // 1: value 1234 shown from frame 2
      strobe(3, 16'h1234, 4'b0000);
      wait_edge(65);
      check("f2_fs", 32'(frame_start), 32'(1'b1));
      wait_edge(66);
      check("f2_fs_low", 32'(frame_start), 32'(1'b0));
      check("d0_an", 32'(an), 32'(4'b1110));
      check("d0_cat4", 32'(cat), 32'(7'b0011001));
      wait_edge(82);
      check("d1_an", 32'(an), 32'(4'b1101));
      check("d1_cat3", 32'(cat), 32'(7'b0110000));
      wait_edge(98);
      check("d2_cat2", 32'(cat), 32'(7'b0100100));
      wait_edge(114);
      check("d3_an", 32'(an), 32'(4'b0111));
      check("d3_cat1", 32'(cat), 32'(7'b1111001));
      wait_edge(129);
      check("f3_fs", 32'(frame_start), 32'(1'b1));

      // 2: brightness 0 from the next slot, then 2 mid-slot
      wait_edge(130); #2; brightness = 2'd0;
      wait_edge(150); #2; brightness = 2'd2;

      // 3: leading-zero suppression
      wait_edge(180); #2; lz_blank = 1'b1;
      strobe(180, 16'h00A0, 4'b0000);
      brightness = 2'd3;
      check("duty_b0", 32'(count_on(145, 160, 1)), 32'd4);
      check("duty_b2", 32'(count_on(161, 176, 2)), 32'd12);
      wait_edge(194);
      check("lz_d0_an", 32'(an), 32'(4'b1110));
      check("lz_d0_cat", 32'(cat), 32'(7'b1000000));
      strobe(200, 16'h0000, 4'b0000);
      wait_edge(210);
      check("lz_d1_an", 32'(an), 32'(4'b1101));
      check("lz_d1_catA", 32'(cat), 32'(7'b0001000));
      wait_edge(226);
      check("lz_d2_blank", 32'(an), 32'(4'b1111));
      wait_edge(242);
      check("lz_d3_blank", 32'(an), 32'(4'b1111));
      wait_edge(258);
      check("zero_d0_an", 32'(an), 32'(4'b1110));
      check("zero_d0_cat", 32'(cat), 32'(7'b1000000));
      wait_edge(274);
      check("zero_d1_blank", 32'(an), 32'(4'b1111));

      // 4: last strobe in a frame wins; wrap-cycle strobe bypasses pending
      wait_edge(300); #2; lz_blank = 1'b0;
      strobe(300, 16'hAAAA, 4'b0000);
      strobe(310, 16'h5555, 4'b0000);
      wait_edge(322);
      check("last_wins_d0", 32'(cat), 32'(7'b0010010));
      wait_edge(370);
      check("last_wins_d3_an", 32'(an), 32'(4'b0111));
      check("last_wins_d3", 32'(cat), 32'(7'b0010010));
      strobe(383, 16'hBEEF, 4'b0000);
      wait_edge(386);
      check("wrap_bypass_F", 32'(cat), 32'(7'b0001110));

      // 5: decimal point on digit 2 only
      strobe(400, 16'hBEEF, 4'b0100);
      wait_edge(402);
      check("wrap_bypass_E", 32'(cat), 32'(7'b0000110));
      wait_edge(434);
      check("wrap_bypass_b", 32'(cat), 32'(7'b0000011));
      wait_edge(450);
      check("dp_d0_off", 32'(dp_out), 32'(1'b1));
      wait_edge(482);
      check("dp_d2_on", 32'(dp_out), 32'(1'b0));
      check("dp_d2_an", 32'(an), 32'(4'b1011));
      wait_edge(498);
      check("dp_d3_off", 32'(dp_out), 32'(1'b1));

      // 6: asynchronous reset at cycle 37 of a frame drops a pending update
      strobe(530, 16'h1111, 4'b1111);
      wait_edge(550); #2;
      rst = 1'b1;
      #1;
      check("async_an", 32'(an), 32'(4'b1111));
      check("async_cat", 32'(cat), 32'(7'b1111111));
      check("async_dp", 32'(dp_out), 32'(1'b1));
      check("async_fs", 32'(frame_start), 32'(1'b0));
      @(posedge clk); #3;
      rst = 1'b0;
      wait_edge(2);
      check("post_rst_d0_an", 32'(an), 32'(4'b1110));
      check("post_rst_d0", 32'(cat), 32'(7'b1000000));
      wait_edge(18);
      check("post_rst_d1", 32'(cat), 32'(7'b1000000));
      wait_edge(66);
      check("post_rst_f2_d0", 32'(cat), 32'(7'b1000000));
      check("post_rst_f2_dp", 32'(dp_out), 32'(1'b1));
      wait_edge(70);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
